// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results straight to writeback and
// runs a req/ack data-memory transaction for loads and stores, stalling upstream.
module mem_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [DATA_W-1:0]  aluresult,
    input  logic [INSTR_W-1:0] instrin,
    input  logic [DATA_W-1:0]  op2_in,
    input  logic               isld,
    input  logic               isst,
    input  logic               iswb,
    input  logic               is_branch_takenin,
    output logic               stall,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               valid_out,
    output logic [DATA_W-1:0]  wbdata,
    output logic [INSTR_W-1:0] instrout,
    output logic               iswb_out
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t             state, state_n;
    logic               accept;
    logic               req_n, we_n, valid_n, iswb_n;
    logic [DATA_W-1:0]  addr_n, wdata_n, wb_n;
    logic [INSTR_W-1:0] instr_n, pend_instr, pend_instr_n;
    logic               pend_iswb, pend_iswb_n;

    assign accept = valid_in & ~is_branch_takenin;
    assign stall  = (state == WAIT_ACK);

    // Next-state and next-output computation; valid_out/iswb_out default to a bubble.
    always_comb begin
        state_n      = state;
        req_n        = mem_req;
        we_n         = mem_we;
        addr_n       = mem_addr;
        wdata_n      = mem_wdata;
        wb_n         = wbdata;
        instr_n      = instrout;
        pend_instr_n = pend_instr;
        pend_iswb_n  = pend_iswb;
        valid_n      = 1'b0;
        iswb_n       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (isld | isst) begin
                        state_n      = WAIT_ACK;
                        req_n        = 1'b1;
                        we_n         = isst & ~isld;
                        addr_n       = aluresult;
                        wdata_n      = op2_in;
                        pend_instr_n = instrin;
                        pend_iswb_n  = iswb;
                    end else begin
                        valid_n = 1'b1;
                        wb_n    = aluresult;
                        instr_n = instrin;
                        iswb_n  = iswb;
                    end
                end
            end
            WAIT_ACK: begin
                // Flush is ignored here: the in-flight access is older than the branch.
                if (mem_ack) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    valid_n = 1'b1;
                    instr_n = pend_instr;
                    if (mem_we) begin
                        wb_n   = mem_addr;
                        iswb_n = 1'b0;
                    end else begin
                        wb_n   = mem_rdata;
                        iswb_n = pend_iswb;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            valid_out  <= 1'b0;
            wbdata     <= '0;
            instrout   <= '0;
            iswb_out   <= 1'b0;
            pend_instr <= '0;
            pend_iswb  <= 1'b0;
        end else begin
            state      <= state_n;
            mem_req    <= req_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
            valid_out  <= valid_n;
            wbdata     <= wb_n;
            instrout   <= instr_n;
            iswb_out   <= iswb_n;
            pend_instr <= pend_instr_n;
            pend_iswb  <= pend_iswb_n;
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. It sits directly downstream of the ALU stage and consumes that stage's outputs: aluresult, instrout, isld1, isst1, op2_out and iswb_out.
- Non-memory instructions pass through to writeback in one cycle.
- Loads and stores run a req/ack transaction with data memory. The stage stalls the upstream pipeline until the ack arrives, then hands the result to writeback.

Parameters:
DATA_W, 16, width of data, address and result buses
INSTR_W, 16, instruction word width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
valid_in  input  1  ALU stage presents an instruction this cycle
aluresult  input  DATA_W  ALU result; memory address for ld/st
instrin  input  INSTR_W  instruction word from ALU stage
op2_in  input  DATA_W  store data (ALU op2_out)
isld  input  1  instruction is a load
isst  input  1  instruction is a store
iswb  input  1  instruction writes the register file
is_branch_takenin  input  1  flush: discard the instruction currently presented
stall  output  1  upstream must hold its inputs
mem_req  output  1  memory request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  DATA_W  memory address
mem_wdata  output  DATA_W  store data
mem_rdata  input  DATA_W  load data, valid with mem_ack
mem_ack  input  1  memory completes the request this cycle
valid_out  output  1  writeback bundle valid
wbdata  output  DATA_W  load data or ALU result
instrout  output  INSTR_W  instruction word to writeback
iswb_out  output  1  register write enable to writeback

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - valid_out, wbdata, instrout, iswb_out = 0.
  - stall=0.
  - A reset during WAIT_ACK abandons the access; mem_req drops immediately.
- States: IDLE, WAIT_ACK.
- stall is combinational: stall = (state==WAIT_ACK).
- Inputs are sampled only in IDLE. Accept condition: valid_in & ~is_branch_takenin.
- IDLE, accept, isld=isst=0 (one-cycle pass-through). On the next edge:
  - valid_out=1, wbdata=aluresult, instrout=instrin, iswb_out=iswb.
  - State stays IDLE, so back-to-back non-memory instructions flow at one per cycle.
- IDLE, accept, isld|isst. On the next edge:
  - mem_req=1, mem_addr=aluresult, mem_wdata=op2_in, mem_we=isst&~isld.
  - instr and iswb are latched internally; valid_out=0; state -> WAIT_ACK.
  - isld and isst both 1 is illegal; it is handled as a load (mem_we=0).
- WAIT_ACK:
  - mem_req, mem_we, mem_addr and mem_wdata hold stable until ack.
  - On a cycle with mem_ack=1, the next edge does the following:
    - mem_req=0, state -> IDLE, valid_out=1, instrout=latched instr.
    - Load: wbdata=mem_rdata, iswb_out=latched iswb.
    - Store: wbdata=mem_addr, iswb_out forced to 0.
- Ack timing: mem_ack is ignored in IDLE. It may arrive in the first WAIT_ACK cycle, giving a minimum of 2 cycles per memory instruction. There is no timeout.
- Flush:
  - is_branch_takenin=1 in IDLE discards the presented instruction; next valid_out=0.
  - is_branch_takenin in WAIT_ACK is ignored: the in-flight access is older and always completes.
- Bubbles (IDLE with no accept): next valid_out=0 and iswb_out=0; wbdata and instrout hold their previous values.
- valid_out is a single-cycle pulse per completed instruction. Writeback has no backpressure.
- All datapath values are passed through unmodified. There is no sign or width conversion; all widths are DATA_W.

Test Plan:
1. Reset: hold reset=0 with mem_ack=1 and valid_in=1 -> all outputs 0, stall=0. Release, no valid_in -> valid_out remains 0.
2. ALU pass-through: three back-to-back cycles, isld=isst=0, aluresult=30/15/240, iswb=1 -> valid_out=1 on three consecutive cycles, wbdata 30,15,240, stall never asserted, mem_req=0.
3. Load with latency: isld=1, aluresult=16'h0040, iswb=1, ack 3 cycles after mem_req, mem_rdata=16'hBEEF -> stall=1 for 3 cycles, mem_addr=16'h0040, mem_we=0, then valid_out=1, wbdata=16'hBEEF, iswb_out=1.
4. Store, immediate ack: isst=1, aluresult=16'h0010, op2_in=16'd7 -> mem_we=1, mem_wdata=7, ack in the first WAIT_ACK cycle, valid_out=1, iswb_out=0, total 2 cycles.
5. Flush: valid_in=1 with is_branch_takenin=1 in IDLE -> no mem_req, valid_out=0. Flush asserted during a WAIT_ACK load -> load still completes with correct wbdata.
6. Reset mid-access: reset=0 during WAIT_ACK -> mem_req and stall drop immediately; after release, a new ADD (aluresult=10) completes normally.
